// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the fetch PC, picks sequential/branch/jump/hold/halt-drain each cycle,
// and drives the IF/ID and ID/EX squash controls.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc4,
    input  logic [31:0] branch_imm,
    input  logic        jump,
    input  logic [31:0] jump_pc4,
    input  logic [25:0] jump_index,
    input  logic        halt,
    output logic [31:0] pc,
    output logic        if_flush,
    output logic        id_flush,
    output logic        halted
);

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StHalted
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        halted_q, halted_d;

    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] seq_pc;

    // Offset is word-scaled, so the top two immediate bits fall off.
    assign branch_target = branch_pc4 + {branch_imm[29:0], 2'b00};
    assign jump_target   = {jump_pc4[31:28], jump_index, 2'b00};
    assign seq_pc        = pc_q + 32'd4;

    logic unused_bits;
    assign unused_bits = ^{branch_imm[31:30], jump_pc4[27:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StRun;
            pc_q     <= RESET_PC;
            cnt_q    <= 4'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        halted_d = halted_q;
        if_flush = 1'b0;
        id_flush = 1'b0;

        unique case (state_q)
            StRun: begin
                if (branch_taken) begin
                    pc_d     = branch_target;
                    if_flush = 1'b1;
                    id_flush = 1'b1;
                end else if (jump && !stall) begin
                    pc_d     = jump_target;
                    if_flush = 1'b1;
                end else if (stall) begin
                    // Hold; a pending jump is re-presented once the stall clears.
                    pc_d = pc_q;
                end else if (halt) begin
                    if_flush = 1'b1;
                    state_d  = StDrain;
                    cnt_d    = 4'(DRAIN_CYCLES - 1);
                end else begin
                    pc_d = seq_pc;
                end
            end
            StDrain: begin
                if_flush = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d  = StHalted;
                    halted_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHalted: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase

        if (reset) begin
            if_flush = 1'b0;
            id_flush = 1'b0;
        end
    end

    assign pc     = pc_q;
    assign halted = halted_q;

endmodule
